// File: rtl/onchip_mem_rr_arbiter_if.sv
// Avalon-MM style master port bundle for onchip_mem_rr_arbiter.
// The lock signal only exists when ARB_LOCK_EN is defined.
interface onchip_mem_rr_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic [AW-1:0]   address;
    logic [DW/8-1:0] byteenable;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
`ifdef ARB_LOCK_EN
    logic            lock;
`endif
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
`ifdef ARB_LOCK_EN
        output lock,
`endif
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM with
// registered address and one-cycle read latency. m0 is the pixel engine, m1
// the host port. Read data is steered back to whichever master issued it.
// Optional feature macro: ARB_LOCK_EN (grant locking, bounded by MAX_LOCK).
module onchip_mem_rr_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
`ifdef ARB_LOCK_EN
    , parameter int MAX_LOCK = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    onchip_mem_rr_arbiter_if.slave   m0,
    onchip_mem_rr_arbiter_if.slave   m1,
    output logic [AW-1:0]            mem_address_o,
    output logic [DW/8-1:0]          mem_byteenable_o,
    output logic                     mem_chipselect_o,
    output logic                     mem_write_o,
    output logic [DW-1:0]            mem_writedata_o,
    output logic                     mem_clken_o,
    input  logic [DW-1:0]            mem_readdata_i
);
    localparam int BW = DW / 8;

    logic            req0_s;
    logic            req1_s;
    logic            prefer_s;      // master that wins a tie this cycle
    logic            gnt_valid_s;
    logic            gnt_sel_s;     // 0 = m0, 1 = m1
    logic [AW-1:0]   sel_addr_s;
    logic [BW-1:0]   sel_be_s;
    logic [DW-1:0]   sel_wdata_s;
    logic            sel_read_s;
    logic            sel_write_s;

    logic            last_grant_q;
    logic            rd_pending_q;
    logic            rd_pending_d;
    logic            rd_owner_q;
    logic            rd_owner_d;
    logic [AW-1:0]   addr_q;
    logic [BW-1:0]   be_q;
    logic [DW-1:0]   wdata_q;

`ifdef ARB_LOCK_EN
    localparam int LCW = $clog2(MAX_LOCK + 1);
    logic            sel_lock_s;
    logic            lock_q;
    logic            lock_d;
    logic            lock_owner_q;
    logic            lock_owner_d;
    logic [LCW-1:0]  lock_cnt_q;
    logic [LCW-1:0]  lock_cnt_d;
`endif

    assign req0_s = m0.read | m0.write;
    assign req1_s = m1.read | m1.write;

    // Tie-break choice: alternate against the last grant unless a lock holds priority.
    always_comb begin
        prefer_s = ~last_grant_q;
`ifdef ARB_LOCK_EN
        if (lock_q && (lock_cnt_q != LCW'(MAX_LOCK - 1))) begin
            prefer_s = lock_owner_q;
        end else begin
            prefer_s = ~last_grant_q;
        end
`endif
    end

    // Grant decision; nothing is accepted while reset is asserted.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_sel_s   = 1'b0;
        if (reset) begin
            gnt_valid_s = 1'b0;
        end else if (req0_s && req1_s) begin
            gnt_valid_s = 1'b1;
            gnt_sel_s   = prefer_s;
        end else if (req0_s) begin
            gnt_valid_s = 1'b1;
            gnt_sel_s   = 1'b0;
        end else if (req1_s) begin
            gnt_valid_s = 1'b1;
            gnt_sel_s   = 1'b1;
        end else begin
            gnt_valid_s = 1'b0;
        end
    end

    // Select the granted master's request fields.
    always_comb begin
        sel_addr_s  = m0.address;
        sel_be_s    = m0.byteenable;
        sel_wdata_s = m0.writedata;
        sel_read_s  = m0.read;
        sel_write_s = m0.write;
        if (gnt_sel_s) begin
            sel_addr_s  = m1.address;
            sel_be_s    = m1.byteenable;
            sel_wdata_s = m1.writedata;
            sel_read_s  = m1.read;
            sel_write_s = m1.write;
        end else begin
            sel_addr_s  = m0.address;
        end
    end

    // RAM side: live request when granted, otherwise park on the last values.
    assign mem_chipselect_o = gnt_valid_s;
    assign mem_write_o      = gnt_valid_s & sel_write_s;
    assign mem_address_o    = gnt_valid_s ? sel_addr_s  : addr_q;
    assign mem_byteenable_o = gnt_valid_s ? sel_be_s    : be_q;
    assign mem_writedata_o  = gnt_valid_s ? sel_wdata_s : wdata_q;
    assign mem_clken_o      = 1'b1;

    assign m0.waitrequest   = req0_s & ~(gnt_valid_s & ~gnt_sel_s);
    assign m1.waitrequest   = req1_s & ~(gnt_valid_s &  gnt_sel_s);

    // A read+write collision is treated as a write, so no data is returned.
    assign rd_pending_d = gnt_valid_s & sel_read_s & ~sel_write_s;
    assign rd_owner_d   = gnt_sel_s;

    assign m0.readdatavalid = rd_pending_q & ~rd_owner_q;
    assign m1.readdatavalid = rd_pending_q &  rd_owner_q;
    assign m0.readdata      = (rd_pending_q & ~rd_owner_q) ? mem_readdata_i : {DW{1'b0}};
    assign m1.readdata      = (rd_pending_q &  rd_owner_q) ? mem_readdata_i : {DW{1'b0}};

    // Arbitration history, read-return tracking and parked RAM-side values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            addr_q       <= {AW{1'b0}};
            be_q         <= {BW{1'b0}};
            wdata_q      <= {DW{1'b0}};
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            if (gnt_valid_s) begin
                last_grant_q <= gnt_sel_s;
                addr_q       <= sel_addr_s;
                be_q         <= sel_be_s;
                wdata_q      <= sel_wdata_s;
            end
        end
    end

`ifdef ARB_LOCK_EN
    assign sel_lock_s   = gnt_sel_s ? m1.lock : m0.lock;
    assign lock_d       = gnt_valid_s & sel_lock_s;
    assign lock_owner_d = gnt_sel_s;

    // Lock run length: counts consecutive locked accepts by the same owner and
    // restarts after the forced release slot.
    always_comb begin
        lock_cnt_d = {LCW{1'b0}};
        if (gnt_valid_s && sel_lock_s && lock_q && (lock_owner_q == gnt_sel_s)
            && (lock_cnt_q != LCW'(MAX_LOCK - 1))) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
        end else begin
            lock_cnt_d = {LCW{1'b0}};
        end
    end

    // Lock state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= {LCW{1'b0}};
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_onchip_mem_rr_arbiter.sv
// Directed bench for onchip_mem_rr_arbiter with a behavioural single-port RAM.
module tb_onchip_mem_rr_arbiter;
    logic        clk;
    logic        reset;
    logic [7:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [256];
    logic [7:0]  ram_addr_q;
    logic        ram_init;

    onchip_mem_rr_arbiter_if #(.AW(8), .DW(32)) m0_if ();
    onchip_mem_rr_arbiter_if #(.AW(8), .DW(32)) m1_if ();

    onchip_mem_rr_arbiter #(
        .AW(8), .DW(32)
`ifdef ARB_LOCK_EN
        , .MAX_LOCK(4)
`endif
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .m0              (m0_if),
        .m1              (m1_if),
        .mem_address_o   (mem_address),
        .mem_byteenable_o(mem_byteenable),
        .mem_chipselect_o(mem_chipselect),
        .mem_write_o     (mem_write),
        .mem_writedata_o (mem_writedata),
        .mem_clken_o     (mem_clken),
        .mem_readdata_i  (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [7:0] a);
        return {8'hA0, a, 8'h5A, a};
    endfunction

    // RAM: registered address, unregistered output, byte-enabled writes.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(8'(i));
            ram[16] <= 32'hCAFEF00D;
            ram[32] <= 32'hFFFFFFFF;
        end else if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            ram_addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    task automatic drive_idle();
        m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = 8'h00;
        m0_if.byteenable = 4'hF; m0_if.writedata = 32'h0;
        m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = 8'h00;
        m1_if.byteenable = 4'hF; m1_if.writedata = 32'h0;
`ifdef ARB_LOCK_EN
        m0_if.lock = 1'b0; m1_if.lock = 1'b0;
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ram_init = 1'b1; ram_addr_q = 8'h00;
        drive_idle();
        repeat (2) @(negedge clk);
        ram_init = 1'b0;
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL reset_rdv got=%b%b exp=00", m0_if.readdatavalid, m1_if.readdatavalid); end
        checks++; if (mem_chipselect !== 1'b0 || mem_clken !== 1'b1) begin
            errors++; $display("FAIL reset_cs_clken got=%b%b exp=01", mem_chipselect, mem_clken); end
        checks++; if (m0_if.waitrequest !== 1'b0) begin
            errors++; $display("FAIL reset_wait_idle got=%b exp=0", m0_if.waitrequest); end
        m0_if.read = 1'b1; m1_if.write = 1'b1;
        #1;
        checks++; if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin
            errors++; $display("FAIL reset_wait_req got=%b%b cs=%b exp=11 cs=0",
                               m0_if.waitrequest, m1_if.waitrequest, mem_chipselect); end
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m0_if.read = 1'b1; m0_if.address = 8'h10;
        #1;
        checks++; if (m0_if.waitrequest !== 1'b0) begin
            errors++; $display("FAIL t1_wait0 got=%b exp=0", m0_if.waitrequest); end
        checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== 8'h10) begin
            errors++; $display("FAIL t1_mem got cs=%b wr=%b a=%h exp cs=1 wr=0 a=10",
                               mem_chipselect, mem_write, mem_address); end
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL t1_rd0 got v=%b d=%h exp v=1 d=cafef00d", m0_if.readdatavalid, m0_if.readdata); end
        checks++; if (m1_if.readdatavalid !== 1'b0 || m1_if.readdata !== 32'h0) begin
            errors++; $display("FAIL t1_rd1 got v=%b d=%h exp v=0 d=0", m1_if.readdatavalid, m1_if.readdata); end
        checks++; if (mem_chipselect !== 1'b0 || mem_address !== 8'h10) begin
            errors++; $display("FAIL t1_idle_hold got cs=%b a=%h exp cs=0 a=10", mem_chipselect, mem_address); end
        @(negedge clk);
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL t1_single_strobe got=%b exp=0", m0_if.readdatavalid); end
    endtask

    task automatic test_fairness();
        logic prev;
        logic [31:0] exp0, exp1;
        apply_reset();
        m0_if.read = 1'b1; m0_if.address = 8'h30;
        m1_if.read = 1'b1; m1_if.address = 8'h31;
        prev = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (m0_if.waitrequest !== (k % 2 != 0) || m1_if.waitrequest !== (k % 2 == 0)) begin
                errors++; $display("FAIL fair_grant k=%0d got wait=%b%b exp grant=%0d",
                                   k, m0_if.waitrequest, m1_if.waitrequest, k % 2); end
            if (k > 0) begin
                exp0 = (prev == 1'b0) ? pat(8'h30) : 32'h0;
                exp1 = (prev == 1'b1) ? pat(8'h31) : 32'h0;
                checks++; if (m0_if.readdatavalid !== ~prev || m1_if.readdatavalid !== prev) begin
                    errors++; $display("FAIL fair_rdv k=%0d got=%b%b exp owner=%0d",
                                       k, m0_if.readdatavalid, m1_if.readdatavalid, prev); end
                checks++; if (m0_if.readdata !== exp0 || m1_if.readdata !== exp1) begin
                    errors++; $display("FAIL fair_data k=%0d got=%h/%h exp=%h/%h",
                                       k, m0_if.readdata, m1_if.readdata, exp0, exp1); end
            end
            prev = (k % 2 != 0);
            @(negedge clk);
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_write_then_read();
        m1_if.write = 1'b1; m1_if.address = 8'h20;
        m1_if.writedata = 32'h12345678; m1_if.byteenable = 4'b0011;
        #1;
        checks++; if (m1_if.waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_byteenable !== 4'b0011) begin
            errors++; $display("FAIL t3_write got wait=%b wr=%b be=%b exp 0 1 0011",
                               m1_if.waitrequest, mem_write, mem_byteenable); end
        @(negedge clk);
        drive_idle();
        m0_if.read = 1'b1; m0_if.address = 8'h20;
        #1;
        checks++; if (m0_if.waitrequest !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL t3_read_issue got wait0=%b rdv1=%b exp 0 0",
                               m0_if.waitrequest, m1_if.readdatavalid); end
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hFFFF5678) begin
            errors++; $display("FAIL t3_merge got v=%b d=%h exp v=1 d=ffff5678", m0_if.readdatavalid, m0_if.readdata); end
        @(negedge clk);
    endtask

    task automatic test_read_write_collision();
        m0_if.read = 1'b1; m0_if.write = 1'b1; m0_if.address = 8'h05;
        m0_if.writedata = 32'h000000A5; m0_if.byteenable = 4'hF;
        #1;
        checks++; if (m0_if.waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin
            errors++; $display("FAIL t4_issue got wait=%b wr=%b cs=%b exp 0 1 1",
                               m0_if.waitrequest, mem_write, mem_chipselect); end
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL t4_no_return got=%b exp=0", m0_if.readdatavalid); end
        m0_if.read = 1'b1; m0_if.address = 8'h05;
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h000000A5) begin
            errors++; $display("FAIL t4_written got v=%b d=%h exp v=1 d=000000a5", m0_if.readdatavalid, m0_if.readdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        m1_if.read = 1'b1; m1_if.address = 8'h40;
        #1;
        checks++; if (m1_if.waitrequest !== 1'b0) begin
            errors++; $display("FAIL t5_accept got=%b exp=0", m1_if.waitrequest); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_idle();
        #1;
        checks++; if (m1_if.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL t5_dropped got=%b exp=0", m1_if.readdatavalid); end
        @(negedge clk);
        checks++; if (m1_if.readdatavalid !== 1'b0 || m0_if.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL t5_in_reset got=%b%b exp=00", m0_if.readdatavalid, m1_if.readdatavalid); end
        @(negedge clk);
        reset = 1'b0;
        m0_if.read = 1'b1; m0_if.address = 8'h50;
        m1_if.read = 1'b1; m1_if.address = 8'h51;
        #1;
        checks++; if (m1_if.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL t5_after_release got=%b exp=0", m1_if.readdatavalid); end
        checks++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1 || mem_address !== 8'h50) begin
            errors++; $display("FAIL t5_first_tie got wait=%b%b a=%h exp 01 a=50",
                               m0_if.waitrequest, m1_if.waitrequest, mem_address); end
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== pat(8'h50)) begin
            errors++; $display("FAIL t5_tie_data got v=%b d=%h exp v=1 d=%h",
                               m0_if.readdatavalid, m0_if.readdata, pat(8'h50)); end
        @(negedge clk);
    endtask

    task automatic test_lock();
        logic [5:0] exp_g;
`ifdef ARB_LOCK_EN
        exp_g = 6'b010000;   // bit k = granted master at cycle k: 0,0,0,0,1,0
`else
        exp_g = 6'b101010;   // 0,1,0,1,0,1
`endif
        apply_reset();
        m0_if.read = 1'b1; m0_if.address = 8'h60;
        m1_if.read = 1'b1; m1_if.address = 8'h61;
`ifdef ARB_LOCK_EN
        m0_if.lock = 1'b1;
`endif
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (m0_if.waitrequest !== exp_g[k] || m1_if.waitrequest !== ~exp_g[k]) begin
                errors++; $display("FAIL lock_seq k=%0d got wait=%b%b exp grant=%0d",
                                   k, m0_if.waitrequest, m1_if.waitrequest, exp_g[k]); end
            @(negedge clk);
        end
        drive_idle();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_write_then_read();
        test_read_write_collision();
        test_reset_mid_read();
        test_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
